// File: rtl/icache.sv
// icache: direct-mapped read-only instruction cache with one-word frames
module icache #(
    parameter int IDX_BITS = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);
    localparam int TW = 30 - IDX_BITS;
    localparam int N = 2 ** IDX_BITS;

    typedef enum logic {IDLE, FETCH} state_t;

    state_t                state;
    logic [29:0]           faddr;
    logic [N-1:0]          valid;
    logic [TW-1:0]         tags [N];
    logic [31:0]           data [N];
    logic [TW-1:0]         tag;
    logic [IDX_BITS-1:0]   idx;
    logic [IDX_BITS-1:0]   fidx;
    logic                  fill;
    logic                  miss;
    logic                  unused_ok;

    assign tag       = imemaddr[31:IDX_BITS+2];
    assign idx       = imemaddr[IDX_BITS+1:2];
    assign fidx      = faddr[IDX_BITS-1:0];
    assign unused_ok = ^imemaddr[1:0];

    // Lookup and memory-side request decode; fetch in flight masks any hit
    always_comb begin
        ihit     = state == IDLE && imemREN && valid[idx] && tags[idx] == tag;
        imemload = ihit ? data[idx] : 32'd0;
        iREN     = state == FETCH;
        iaddr    = iREN ? {faddr, 2'b00} : 32'd0;
        fill     = state == FETCH && !iwait;
        miss     = state == IDLE && imemREN && !ihit;
    end

    // Control state, valid bits and saturating counters; reset abandons a fetch
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            faddr      <= '0;
            valid      <= '0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (miss) begin
                state <= FETCH;
                faddr <= imemaddr[31:2];
            end else if (fill) begin
                state       <= IDLE;
                valid[fidx] <= 1'b1;
            end
            if (ihit && hit_count != 32'hFFFF_FFFF) hit_count <= hit_count + 32'd1;
            if (miss && miss_count != 32'hFFFF_FFFF) miss_count <= miss_count + 32'd1;
        end
    end

    // Frame fill from the latched address; conflicting frames are simply overwritten
    always_ff @(posedge CLK) begin
        if (fill) begin
            tags[fidx] <= faddr[29:IDX_BITS];
            data[fidx] <= iload;
        end
    end
endmodule

// File: doc/icache.md
ICACHE -- requirements
Module: icache

Interface
REQ-001 SHALL have parameter IDX_BITS, default 4, meaning frame-index width (2**IDX_BITS direct-mapped one-word frames).
REQ-002 SHALL have port CLK  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port imemREN  input  1  datapath fetch request.
REQ-005 SHALL have port imemaddr  input  32  datapath fetch address (PC).
REQ-006 SHALL have port ihit  output  1  fetch data valid this cycle.
REQ-007 SHALL have port imemload  output  32  fetched instruction.
REQ-008 SHALL have port iREN  output  1  memory read request.
REQ-009 SHALL have port iaddr  output  32  memory read address.
REQ-010 SHALL have port iwait  input  1  memory busy; low means iload valid this cycle.
REQ-011 SHALL have port iload  input  32  memory read data.
REQ-012 SHALL have port hit_count  output  32  completed hits, saturating.
REQ-013 SHALL have port miss_count  output  32  misses started, saturating.

Function
REQ-014 SHALL split addresses as tag = addr[31:IDX_BITS+2], idx = addr[IDX_BITS+1:2], addr[1:0] ignored.
REQ-015 SHALL keep per frame: valid (1), tag (30-IDX_BITS), data (32).
REQ-016 SHALL implement FSM states IDLE and FETCH only.
REQ-017 In IDLE, ihit SHALL be combinationally 1 iff imemREN=1, valid[idx]=1, tag[idx]=tag(imemaddr); imemload SHALL then equal data[idx].
REQ-018 imemload SHALL be 0 whenever ihit=0.
REQ-019 In IDLE with imemREN=1 and no hit, FSM SHALL go to FETCH next edge, latch imemaddr[31:2] as fetch address, increment miss_count.
REQ-020 In IDLE with imemREN=0, no state change, iREN=0, ihit=0.
REQ-021 In FETCH, iREN SHALL be 1 and iaddr SHALL equal {latched address, 2'b00}; in IDLE iREN=0 and iaddr=0.
REQ-022 In FETCH, ihit SHALL be 0 regardless of imemaddr.
REQ-023 In FETCH with iwait=0, next edge SHALL write data=iload, tag and valid=1 into the latched idx, and return to IDLE.
REQ-024 In FETCH with iwait=1, FSM SHALL stay in FETCH with no array change.
REQ-025 A FETCH SHALL complete even if imemREN drops or imemaddr changes mid-fetch (branch/jump redirect); fill uses the latched address; IDLE then re-evaluates the current imemaddr.
REQ-026 Miss latency: ihit for a missed address SHALL rise exactly one cycle after the cycle iwait=0 was sampled in FETCH.
REQ-027 A fill SHALL overwrite any valid frame at the same idx (conflict eviction, no write-back).
REQ-028 hit_count SHALL increment on each rising edge where ihit=1; both counters SHALL hold at 32'hFFFFFFFF.
REQ-029 Cache SHALL be read-only; no datapath write path exists.

Reset
REQ-030 While RST=1 (asynchronously): all valid bits 0, FSM IDLE, latched address 0, hit_count=0, miss_count=0; hence iREN=0, iaddr=0, ihit=0, imemload=0.
REQ-031 RST asserted during FETCH SHALL abandon the fetch with no frame written; tag/data arrays need not reset.
REQ-032 First edge after RST deasserts SHALL be normal operation.

Verification
REQ-033 Cold miss: after reset, imemREN=1, imemaddr=0x0000_0040, iwait=1 for 3 cycles then 0 with iload=0x2001_0005 -> iREN=1, iaddr=0x40 for 4 cycles; next cycle ihit=1, imemload=0x2001_0005; miss_count=1.
REQ-034 Repeat hit: hold imemaddr=0x40 for 5 cycles after fill -> ihit=1 every cycle, iREN=0, hit_count=5.
REQ-035 Conflict: with IDX_BITS=4, fill 0x40 then request 0x440 -> miss, fetch iaddr=0x440, frame 0 replaced; then 0x40 misses again; miss_count=3.
REQ-036 Redirect mid-fetch: miss on 0x80, change imemaddr to 0x100 while iwait=1 -> iaddr stays 0x80 until iwait=0, 0x80 filled, then FETCH of 0x100 begins next cycle.
REQ-037 Reset mid-fetch: RST=1 during FETCH of 0x80 -> iREN=0 immediately; after release, 0x80 misses (valid cleared), counters 0.
REQ-038 Byte offset: fill 0x40, request 0x43 -> ihit=1, same data.
